// File: rtl/sram_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_if
// Brief    : MEM-stage request/response bundle between the CPU and the SRAM
//            sequencer.
// Revision : 1.0
// ============================================================================
interface sram_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] mem_result;
  logic        ready;

  modport master (
    output mem_read, mem_write, address, data,
    input  mem_result, ready
  );

  modport slave (
    input  mem_read, mem_write, address, data,
    output mem_result, ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_controller
// Brief    : Splits each 32-bit load/store into two 16-bit asynchronous SRAM
//            cycles with WAIT_CYCLES extra cycles per half; stalls via ready.
//            Optional macro SRAM_ALIGN_CHECK_EN adds misaligned-access
//            rejection and a sticky align_err output.
// Revision : 1.0
// ============================================================================
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  wire logic               clk,
  input  wire logic               rst,
  sram_mem_if.slave               bus,
  output logic [SRAM_AW-1:0]      sram_addr,
  inout  wire  [15:0]             sram_dq,
  output logic                    sram_we_n
`ifdef SRAM_ALIGN_CHECK_EN
  ,
  output logic                    align_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = WAIT_CYCLES[3:0];

  state_t               state;
  logic   [3:0]         cnt;
  logic                 is_write;
  logic   [15:0]        data_hi;
  logic   [15:0]        lo_half;
  logic   [15:0]        dq_out;
  logic                 dq_oe;
  logic                 req;
  logic                 misaligned;
  logic   [SRAM_AW-1:0] lo_addr;

  assign req = bus.mem_read | bus.mem_write;

  // Word index wraps modulo 2^(SRAM_AW-1) via the truncating cast.
  assign lo_addr = SRAM_AW'(((bus.address - 32'(ADDR_BASE)) >> 2) << 1);

`ifdef SRAM_ALIGN_CHECK_EN
  assign misaligned = |bus.address[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign sram_dq   = dq_oe ? dq_out : 16'bz;
  assign bus.ready = (state == DONE) || ((state == IDLE) && !req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      is_write       <= 1'b0;
      data_hi        <= 16'd0;
      lo_half        <= 16'd0;
      dq_out         <= 16'd0;
      dq_oe          <= 1'b0;
      sram_addr      <= '0;
      sram_we_n      <= 1'b1;
      bus.mem_result <= 32'd0;
`ifdef SRAM_ALIGN_CHECK_EN
      align_err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req && misaligned) begin
            state <= DONE;
`ifdef SRAM_ALIGN_CHECK_EN
            align_err <= 1'b1;
`endif
          end else if (req) begin
            // Write wins when both requests are present.
            state     <= LO;
            cnt       <= 4'd0;
            is_write  <= bus.mem_write;
            data_hi   <= bus.data[31:16];
            dq_out    <= bus.data[15:0];
            dq_oe     <= bus.mem_write;
            sram_we_n <= ~bus.mem_write;
            sram_addr <= lo_addr;
          end
        end
        LO: begin
          if (cnt == WAIT_LAST) begin
            state     <= HI;
            cnt       <= 4'd0;
            lo_half   <= sram_dq;
            dq_out    <= data_hi;
            sram_addr <= {sram_addr[SRAM_AW-1:1], 1'b1};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (cnt == WAIT_LAST) begin
            state     <= DONE;
            cnt       <= 4'd0;
            sram_we_n <= 1'b1;
            dq_oe     <= 1'b0;
            if (!is_write) begin
              bus.mem_result <= {sram_dq, lo_half};
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_mem_controller
// Brief    : Self-checking bench with an SRAM model and a word-level reference.
// Revision : 1.0
// ============================================================================
module tb_sram_mem_controller;

  localparam int W    = 1;
  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int EXP_STALL = 2 * (W + 1) + 1;
  localparam int EXP_WLOW  = 2 * (W + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_mem_if bus ();
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
`ifdef SRAM_ALIGN_CHECK_EN
  logic          align_err;
`endif

  sram_mem_controller #(
    .WAIT_CYCLES (W),
    .ADDR_BASE   (BASE),
    .SRAM_AW     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n)
`ifdef SRAM_ALIGN_CHECK_EN
    ,
    .align_err (align_err)
`endif
  );

  // Asynchronous SRAM model: drives the bus whenever not being written.
  logic [15:0]   sram_mem [0:(1<<AW)-1];
  logic          preload_en = 1'b0;
  logic [AW-1:0] pre_a;
  logic [15:0]   pre_d;
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'bz;
  always @(posedge clk) begin
    if (!sram_we_n)      sram_mem[sram_addr] <= sram_dq;
    else if (preload_en) sram_mem[pre_a]     <= pre_d;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_result;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] diff;
    diff = a - BASE;
    return int'((diff >> 2) % (32'd1 << (AW - 1)));
  endfunction

  task automatic preload(input int ha, input logic [15:0] d);
    @(negedge clk);
    pre_a = AW'(ha); pre_d = d; preload_en = 1'b1;
    @(negedge clk);
    preload_en = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output int stalls, output int wlow);
    @(negedge clk);
    bus.mem_read = rd; bus.mem_write = wr; bus.address = a; bus.data = d;
    stalls = 0; wlow = 0;
    #1;
    while (bus.ready !== 1'b1 && stalls < 100) begin
      if (sram_we_n === 1'b0) wlow++;
      stalls++;
      @(negedge clk);
      #1;
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.address = '0; bus.data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL reset_we_n got=%b want=1", sram_we_n); end
    n_cmp++; if (sram_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
    n_cmp++; if (bus.mem_result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h want=0", bus.mem_result); end
    @(negedge clk);
    rst = 1'b0;
    exp_result = 32'd0;
  endtask

  task automatic test_store_load();
    int s, wl;
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, s, wl);
    ref_mem[0] = 32'hDEADBEEF;
    n_cmp++; if (s != EXP_STALL) begin n_err++; $display("FAIL store_stall got=%0d want=%0d", s, EXP_STALL); end
    n_cmp++; if (wl != EXP_WLOW) begin n_err++; $display("FAIL store_we_low got=%0d want=%0d", wl, EXP_WLOW); end
    n_cmp++; if (sram_mem[0] !== 16'hBEEF) begin n_err++; $display("FAIL store_hw0 got=%h want=beef", sram_mem[0]); end
    n_cmp++; if (sram_mem[1] !== 16'hDEAD) begin n_err++; $display("FAIL store_hw1 got=%h want=dead", sram_mem[1]); end
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL store_result_hold got=%h want=%h", bus.mem_result, exp_result); end
    access(1'b1, 1'b0, 32'd1024, 32'h0, s, wl);
    exp_result = ref_mem[0];
    n_cmp++; if (s != EXP_STALL) begin n_err++; $display("FAIL load_stall got=%0d want=%0d", s, EXP_STALL); end
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL load_result got=%h want=%h", bus.mem_result, exp_result); end
  endtask

  task automatic test_preloaded_read();
    int s, wl;
    preload(2, 16'h1234);
    preload(3, 16'hABCD);
    ref_mem[1] = 32'hABCD1234;
    access(1'b1, 1'b0, 32'd1028, 32'h0, s, wl);
    exp_result = ref_mem[1];
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL preload_result got=%h want=%h", bus.mem_result, exp_result); end
    n_cmp++; if (wl != 0) begin n_err++; $display("FAIL read_we_low got=%0d want=0", wl); end
    // Result must survive idle cycles.
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL idle_hold got=%h want=%h", bus.mem_result, exp_result); end
  endtask

  task automatic test_both_requests();
    int s, wl;
    access(1'b1, 1'b1, 32'd1032, 32'h0000FFFF, s, wl);
    ref_mem[2] = 32'h0000FFFF;
    n_cmp++; if (sram_mem[4] !== 16'hFFFF) begin n_err++; $display("FAIL both_hw4 got=%h want=ffff", sram_mem[4]); end
    n_cmp++; if (sram_mem[5] !== 16'h0000) begin n_err++; $display("FAIL both_hw5 got=%h want=0000", sram_mem[5]); end
    n_cmp++; if (wl != EXP_WLOW) begin n_err++; $display("FAIL both_we_low got=%0d want=%0d", wl, EXP_WLOW); end
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL both_result got=%h want=%h", bus.mem_result, exp_result); end
  endtask

  task automatic test_wrap();
    int s, wl;
    logic [31:0] d;
    d = $urandom;
    access(1'b0, 1'b1, 32'(BASE + (1 << (AW + 1))), d, s, wl);
    ref_mem[word_of(32'(BASE + (1 << (AW + 1))))] = d;
    n_cmp++; if (sram_mem[0] !== d[15:0]) begin n_err++; $display("FAIL wrap_hw0 got=%h want=%h", sram_mem[0], d[15:0]); end
    n_cmp++; if (sram_mem[1] !== d[31:16]) begin n_err++; $display("FAIL wrap_hw1 got=%h want=%h", sram_mem[1], d[31:16]); end
    access(1'b1, 1'b0, 32'd1024, 32'h0, s, wl);
    exp_result = ref_mem[0];
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL wrap_read got=%h want=%h", bus.mem_result, exp_result); end
  endtask

  task automatic test_random();
    int s, wl, slot, widx;
    bit rd;
    logic [31:0] a, d;
    for (int i = 0; i < 40; i++) begin
      slot = int'($urandom_range(0, 15));
      widx = (slot < 12) ? slot : ((1 << (AW - 1)) - 1 - (slot - 12));
      a = 32'(BASE) + 32'(widx) * 32'd4;
      d = $urandom;
      rd = $urandom_range(0, 1) == 1 && ref_mem.exists(widx);
      access(rd, !rd, a, d, s, wl);
      n_cmp++; if (s != EXP_STALL) begin n_err++; $display("FAIL rand_stall[%0d] got=%0d want=%0d", i, s, EXP_STALL); end
      if (rd) exp_result = ref_mem[widx];
      else    ref_mem[widx] = d;
      n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL rand_result[%0d] got=%h want=%h", i, bus.mem_result, exp_result); end
    end
  endtask

  task automatic test_ignore_changes();
    int n;
    @(negedge clk);
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.address = 32'd1024; bus.data = 32'h0;
    @(negedge clk);
    // Mid-access the pipeline must not be able to redirect the controller.
    bus.mem_write = 1'b1; bus.address = 32'd1028; bus.data = 32'h5555AAAA;
    n = 0;
    #1;
    while (bus.ready !== 1'b1 && n < 100) begin n++; @(negedge clk); #1; end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    exp_result = ref_mem[0];
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL ignore_result got=%h want=%h", bus.mem_result, exp_result); end
    n_cmp++; if (n != EXP_STALL - 1) begin n_err++; $display("FAIL ignore_stall got=%0d want=%0d", n, EXP_STALL - 1); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    bus.mem_write = 1'b1; bus.mem_read = 1'b0; bus.address = 32'd1040; bus.data = $urandom;
    repeat (W + 3) @(negedge clk);
    #1;
    n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL midwr_we_n got=%b want=0", sram_we_n); end
    rst = 1'b1; bus.mem_write = 1'b0;
    #1;
    n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL abort_we_n got=%b want=1", sram_we_n); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got=%b want=1", bus.ready); end
    n_cmp++; if (sram_dq !== sram_mem[sram_addr]) begin n_err++; $display("FAIL abort_bus got=%h want=%h", sram_dq, sram_mem[sram_addr]); end
    @(negedge clk);
    rst = 1'b0;
    ref_mem.delete(4);
    exp_result = 32'd0;
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b want=1", bus.ready); end
  endtask

`ifdef SRAM_ALIGN_CHECK_EN
  task automatic test_align();
    int s, wl;
    n_cmp++; if (align_err !== 1'b0) begin n_err++; $display("FAIL align_err_init got=%b want=0", align_err); end
    access(1'b1, 1'b0, 32'd1026, 32'h0, s, wl);
    n_cmp++; if (s != 1) begin n_err++; $display("FAIL align_stall got=%0d want=1", s); end
    n_cmp++; if (align_err !== 1'b1) begin n_err++; $display("FAIL align_err got=%b want=1", align_err); end
    n_cmp++; if (sram_addr !== '0) begin n_err++; $display("FAIL align_addr got=%h want=0", sram_addr); end
    n_cmp++; if (bus.mem_result !== exp_result) begin n_err++; $display("FAIL align_result got=%h want=%h", bus.mem_result, exp_result); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_preloaded_read();
    test_both_requests();
    test_wrap();
    test_random();
    test_ignore_changes();
    test_reset_mid_write();
`ifdef SRAM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
